down_count_sched: RTL and testbench
===================================

Name: down_count_sched

Overview:
- Round-robin scheduler that shares one down counter among N_REQ requesters. Each requester asks for a countdown of a programmed length.
- The block arbitrates between requests, loads the counter with the winner's value and decrements once per clock. When the counter reaches zero it returns a one-cycle done pulse to that requester.
- Sits between requesting control FSMs and the shared timing resource. It replaces per-client free-running down counters.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- CNT_W, 4, counter width; idle/reset count value is all-ones (15 at default)

Ports:
- clk  input  1  clock, all logic on posedge
- rst  input  1  synchronous, active-high reset
- req  input  N_REQ  per-requester request level; must be held until done, dropping it aborts
- load_val  input  N_REQ*CNT_W  countdown length per requester; slice i = load_val[i*CNT_W +: CNT_W]; sampled only at grant
- grant  output  N_REQ  one-hot owner of the counter, registered, zero when idle
- busy  output  1  high while counter is owned (COUNT or DONE state)
- count  output  CNT_W  shared counter value
- done  output  N_REQ  one-cycle pulse to the owner on expiry

Behaviour:
- Reset (rst=1 at posedge) forces:
  - state=IDLE, grant=0, busy=0, done=0, count=all-ones
  - rr pointer=N_REQ-1, so requester 0 has top priority first
- Reset wins over every other event, including mid-count. No done is issued for a countdown killed by reset.
- States: IDLE, COUNT, DONE.
- IDLE:
  - count held at all-ones; grant=0.
  - If any req bit is high at a posedge, the winner is the first set bit searching upward from ptr+1, wrapping modulo N_REQ.
  - On that edge: grant<=onehot(winner), count<=load_val slice of winner, ptr<=winner, busy<=1, state<=COUNT.
- COUNT:
  - If req[owner]==0 at the edge (abort): state<=IDLE, grant<=0, busy<=0, count<=all-ones, no done. The ptr keeps the aborted owner.
  - Else if count==0: state<=DONE, done[owner]<=1, grant<=0, count<=all-ones.
  - Else count<=count-1.
  - Abort is checked before expiry.
- DONE:
  - done pulse visible for exactly one cycle; busy still 1; no arbitration in this state.
  - Next edge: done<=0, busy<=0, state<=IDLE.
- Latency: req seen at edge t gives grant and count=L after t. Count reads L-k after edge t+k. done is high between edges t+L+1 and t+L+2. The earliest next grant is at edge t+L+3.
- L=0: count is 0 in the first COUNT cycle, so done follows at edge t+1.
- No wrap-around: count never decrements below 0 and never reloads from 0 except through DONE/IDLE.
- load_val changes after grant are ignored. req from non-owners while busy is ignored and not queued; it is re-arbitrated in IDLE.
- grant, busy and done are mutually consistent:
  - done is never high together with grant.
  - At most one bit of grant or done is set.
- No combinational paths from inputs to outputs.

Test Plan:
- Reset/idle: assert rst 2 cycles, then req=0 -> count=15, grant=0, busy=0, done=0, and they stay so for 10 cycles.
- Single request:
  - Stimulus: req=4'b0100, slice2=5, asserted before edge t.
  - Response: grant=4'b0100 and count=5 after t; count steps 4,3,2,1,0; done=4'b0100 for exactly one cycle after edge t+6; busy falls after t+7; count returns to 15.
- Round-robin fairness:
  - Stimulus: req=4'b1011 held continuously, all slices=1.
  - Response: grant order 0,1,3,0,1,3; each owner gets exactly one done per grant.
- Zero length: slice0=0, req=4'b0001 -> count=0 after grant edge t; done[0] after t+1; busy low after t+2.
- Abort: slice1=9; drop req[1] while count=6 -> next edge grant=0, count=15, busy=0, done never pulses. Re-arbitration starts from requester 2.
- Reset mid-operation: assert rst while count=3 with req=4'b0001 held -> outputs return to reset values on that edge with no done. After rst releases, requester 0 is granted again.

Source files
------------

// File: rtl/down_count_sched_if.sv
// down_count_sched_if: request/grant bundle between requesters and the shared down-counter scheduler.
interface down_count_sched_if #(
    parameter int N_REQ = 4,
    parameter int CNT_W = 4
);
    logic [N_REQ-1:0]       req;
    logic [N_REQ*CNT_W-1:0] load_val;
    logic [N_REQ-1:0]       grant;
    logic                   busy;
    logic [CNT_W-1:0]       count;
    logic [N_REQ-1:0]       done;

    modport master (output req, load_val, input grant, busy, count, done);
    modport slave  (input req, load_val, output grant, busy, count, done);
endinterface

// File: rtl/down_count_sched.sv
// down_count_sched: round-robin sharing of one down counter, one-cycle done pulse to the owner on expiry.
module down_count_sched #(
    parameter int N_REQ = 4,
    parameter int CNT_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    down_count_sched_if.slave  bus
);
    localparam int PW = $clog2(N_REQ);

    typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

    state_t           state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [N_REQ-1:0] done_q, done_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [PW-1:0]    win;
    logic             found;

    // First set request searching upward from ptr+1, wrapping.
    always_comb begin
        win   = '0;
        found = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            int j;
            j = int'(ptr_q) + k;
            if (j >= N_REQ) j = j - N_REQ;
            if (!found && bus.req[j]) begin
                found = 1'b1;
                win   = PW'(j);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        count_d = count_q;
        ptr_d   = ptr_q;
        done_d  = '0;
        case (state_q)
            IDLE: if (found) begin
                grant_d      = '0;
                grant_d[win] = 1'b1;
                count_d      = bus.load_val[win*CNT_W +: CNT_W];
                ptr_d        = win;
                state_d      = COUNT;
            end
            COUNT: begin
                if (!bus.req[ptr_q]) begin
                    state_d = IDLE;
                    grant_d = '0;
                    count_d = '1;
                end else if (count_q == '0) begin
                    state_d       = DONE;
                    done_d[ptr_q] = 1'b1;
                    grant_d       = '0;
                    count_d       = '1;
                end else begin
                    count_d = count_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            done_q  <= '0;
            count_q <= '1;
            ptr_q   <= PW'(N_REQ - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            count_q <= count_d;
            ptr_q   <= ptr_d;
        end
    end

    assign bus.grant = grant_q;
    assign bus.done  = done_q;
    assign bus.count = count_q;
    assign bus.busy  = (state_q != IDLE);
endmodule

// File: tb/tb_down_count_sched.sv
// tb_down_count_sched: directed scenarios; observed vector is {grant, busy, count, done}.
module tb_down_count_sched;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    down_count_sched_if #(.N_REQ(4), .CNT_W(4)) bus ();

    down_count_sched #(.N_REQ(4), .CNT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    wire [12:0] obs = {bus.grant, bus.busy, bus.count, bus.done};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req = '0;
        bus.load_val = '0;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_cmp++;
            if (obs !== {4'b0000, 1'b0, 4'd15, 4'b0000}) begin
                n_err++;
                $display("FAIL reset_idle cyc=%0d got=%b want=%b", i, obs, {4'b0000, 1'b0, 4'd15, 4'b0000});
            end
        end
    endtask

    task automatic test_single();
        bus.req = 4'b0100;
        bus.load_val = {4'd0, 4'd5, 4'd0, 4'd0};
        for (int k = 0; k <= 5; k++) begin
            tick();
            n_cmp++;
            if (obs !== {4'b0100, 1'b1, 4'(5 - k), 4'b0000}) begin
                n_err++;
                $display("FAIL single_count k=%0d got=%b want=%b", k, obs, {4'b0100, 1'b1, 4'(5 - k), 4'b0000});
            end
        end
        tick();
        n_cmp++;
        if (obs !== {4'b0000, 1'b1, 4'd15, 4'b0100}) begin
            n_err++;
            $display("FAIL single_done got=%b want=%b", obs, {4'b0000, 1'b1, 4'd15, 4'b0100});
        end
        bus.req = '0;
        tick();
        n_cmp++;
        if (obs !== {4'b0000, 1'b0, 4'd15, 4'b0000}) begin
            n_err++;
            $display("FAIL single_idle got=%b want=%b", obs, {4'b0000, 1'b0, 4'd15, 4'b0000});
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] order [6] = '{4'b0001, 4'b0010, 4'b1000, 4'b0001, 4'b0010, 4'b1000};
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.req = 4'b1011;
        bus.load_val = {4'd1, 4'd1, 4'd1, 4'd1};
        for (int g = 0; g < 6; g++) begin
            tick();
            n_cmp++;
            if (obs !== {order[g], 1'b1, 4'd1, 4'b0000}) begin
                n_err++;
                $display("FAIL rr_grant g=%0d got=%b want=%b", g, obs, {order[g], 1'b1, 4'd1, 4'b0000});
            end
            tick();
            n_cmp++;
            if (obs !== {order[g], 1'b1, 4'd0, 4'b0000}) begin
                n_err++;
                $display("FAIL rr_zero g=%0d got=%b want=%b", g, obs, {order[g], 1'b1, 4'd0, 4'b0000});
            end
            tick();
            n_cmp++;
            if (obs !== {4'b0000, 1'b1, 4'd15, order[g]}) begin
                n_err++;
                $display("FAIL rr_done g=%0d got=%b want=%b", g, obs, {4'b0000, 1'b1, 4'd15, order[g]});
            end
            tick();
            n_cmp++;
            if (obs !== {4'b0000, 1'b0, 4'd15, 4'b0000}) begin
                n_err++;
                $display("FAIL rr_idle g=%0d got=%b want=%b", g, obs, {4'b0000, 1'b0, 4'd15, 4'b0000});
            end
        end
        bus.req = '0;
    endtask

    task automatic test_zero_length();
        bus.req = 4'b0001;
        bus.load_val = {4'd7, 4'd7, 4'd7, 4'd0};
        tick();
        n_cmp++;
        if (obs !== {4'b0001, 1'b1, 4'd0, 4'b0000}) begin
            n_err++;
            $display("FAIL zero_grant got=%b want=%b", obs, {4'b0001, 1'b1, 4'd0, 4'b0000});
        end
        tick();
        n_cmp++;
        if (obs !== {4'b0000, 1'b1, 4'd15, 4'b0001}) begin
            n_err++;
            $display("FAIL zero_done got=%b want=%b", obs, {4'b0000, 1'b1, 4'd15, 4'b0001});
        end
        bus.req = '0;
        tick();
        n_cmp++;
        if (obs !== {4'b0000, 1'b0, 4'd15, 4'b0000}) begin
            n_err++;
            $display("FAIL zero_idle got=%b want=%b", obs, {4'b0000, 1'b0, 4'd15, 4'b0000});
        end
    endtask

    task automatic test_abort();
        bus.req = 4'b0010;
        bus.load_val = {4'd3, 4'd3, 4'd9, 4'd3};
        for (int k = 0; k <= 3; k++) begin
            tick();
            bus.load_val = {4'd3, 4'd3, 4'd2, 4'd3};
            n_cmp++;
            if (obs !== {4'b0010, 1'b1, 4'(9 - k), 4'b0000}) begin
                n_err++;
                $display("FAIL abort_count k=%0d got=%b want=%b", k, obs, {4'b0010, 1'b1, 4'(9 - k), 4'b0000});
            end
        end
        bus.req = 4'b0000;
        tick();
        n_cmp++;
        if (obs !== {4'b0000, 1'b0, 4'd15, 4'b0000}) begin
            n_err++;
            $display("FAIL abort_drop got=%b want=%b", obs, {4'b0000, 1'b0, 4'd15, 4'b0000});
        end
        bus.req = 4'b1111;
        bus.load_val = {4'd4, 4'd4, 4'd4, 4'd4};
        tick();
        n_cmp++;
        if (obs !== {4'b0100, 1'b1, 4'd4, 4'b0000}) begin
            n_err++;
            $display("FAIL abort_rearb got=%b want=%b", obs, {4'b0100, 1'b1, 4'd4, 4'b0000});
        end
        bus.req = '0;
        tick();
        n_cmp++;
        if (obs !== {4'b0000, 1'b0, 4'd15, 4'b0000}) begin
            n_err++;
            $display("FAIL abort_second got=%b want=%b", obs, {4'b0000, 1'b0, 4'd15, 4'b0000});
        end
    endtask

    task automatic test_reset_mid();
        bus.req = 4'b0001;
        bus.load_val = {4'd0, 4'd0, 4'd0, 4'd5};
        tick();
        tick();
        tick();
        n_cmp++;
        if (obs !== {4'b0001, 1'b1, 4'd3, 4'b0000}) begin
            n_err++;
            $display("FAIL rstmid_pre got=%b want=%b", obs, {4'b0001, 1'b1, 4'd3, 4'b0000});
        end
        rst = 1'b1;
        tick();
        n_cmp++;
        if (obs !== {4'b0000, 1'b0, 4'd15, 4'b0000}) begin
            n_err++;
            $display("FAIL rstmid_kill got=%b want=%b", obs, {4'b0000, 1'b0, 4'd15, 4'b0000});
        end
        rst = 1'b0;
        tick();
        n_cmp++;
        if (obs !== {4'b0001, 1'b1, 4'd5, 4'b0000}) begin
            n_err++;
            $display("FAIL rstmid_regrant got=%b want=%b", obs, {4'b0001, 1'b1, 4'd5, 4'b0000});
        end
        tick();
        n_cmp++;
        if (obs !== {4'b0001, 1'b1, 4'd4, 4'b0000}) begin
            n_err++;
            $display("FAIL rstmid_count got=%b want=%b", obs, {4'b0001, 1'b1, 4'd4, 4'b0000});
        end
        bus.req = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_zero_length();
        test_abort();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
